// File: rtl/rob_commit_arb_pkg.sv
// Shared constants and payload type for the ROB commit arbiter.
// Holds the default commit-source count, the RS source indices and the
// ROB-side field widths used by the interface, the arbiter and the bench.
package rob_commit_arb_pkg;

    localparam int unsigned PORT_NUM_DEF = 4;

    // Reservation-station commit source order
    localparam int unsigned RS_INT    = 0;
    localparam int unsigned RS_MDU    = 1;
    localparam int unsigned RS_MEM    = 2;
    localparam int unsigned RS_BRANCH = 3;

    localparam int unsigned ROB_ADDR_W = 6;
    localparam int unsigned EXC_TYPE_W = 4;
    localparam int unsigned DATA_W     = 32;

    // One committed entry as carried from an RS to the ROB
    typedef struct packed {
        logic [ROB_ADDR_W-1:0] addr;
        logic [EXC_TYPE_W-1:0] exc_type;
        logic [DATA_W-1:0]     data;
    } commit_entry_t;

endpackage

// File: rtl/rob_commit_arb_if.sv
// Commit bus between the reservation stations, the commit arbiter and the ROB.
// Signals:
//   flush                      pipeline flush from ROB
//   can_commit / commit_*      per-RS offered entry
//   commit_en                  one-hot grant back to the RSs
//   rob_ready                  ROB accepts the held entry
//   rob_write_en / rob_*       held entry toward the ROB
// Modports: slave = arbiter view, master = RS/ROB (environment) view.
interface rob_commit_arb_if
    import rob_commit_arb_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_DEF
) ();

    logic                                 flush;
    logic [PORT_NUM-1:0]                  can_commit;
    logic [PORT_NUM-1:0][ROB_ADDR_W-1:0]  commit_addr;
    logic [PORT_NUM-1:0][EXC_TYPE_W-1:0]  commit_exc_type;
    logic [PORT_NUM-1:0][DATA_W-1:0]      commit_data;
    logic [PORT_NUM-1:0]                  commit_en;
    logic                                 rob_ready;
    logic                                 rob_write_en;
    logic [ROB_ADDR_W-1:0]                rob_addr;
    logic [EXC_TYPE_W-1:0]                rob_exc_type;
    logic [DATA_W-1:0]                    rob_data;

    modport slave (
        input  flush, can_commit, commit_addr, commit_exc_type, commit_data, rob_ready,
        output commit_en, rob_write_en, rob_addr, rob_exc_type, rob_data
    );

    modport master (
        output flush, can_commit, commit_addr, commit_exc_type, commit_data, rob_ready,
        input  commit_en, rob_write_en, rob_addr, rob_exc_type, rob_data
    );

endinterface

// File: rtl/rob_commit_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found starting
// at ptr and wrapping modulo N. Purely combinational; reusable for CDB.
// Ports:
//   req    request vector
//   ptr    highest-priority index
//   grant  one-hot grant (zero when no request)
module rob_commit_arb_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan N positions starting at ptr; first hit wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_commit_arb.sv
// ROB commit arbiter: picks one RS commit entry per cycle round-robin and
// holds it in a single output slot until the ROB accepts it.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        commit bus (slave modport): RS offers in, commit_en grant
//              out, registered rob_* slot toward the ROB
module rob_commit_arb
    import rob_commit_arb_pkg::*;
#(
    parameter int unsigned PORT_NUM = PORT_NUM_DEF
) (
    input  logic                clk,
    input  logic                rst,
    rob_commit_arb_if.slave     bus
);

    localparam int unsigned PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic              slot_valid;
    commit_entry_t     slot;
    logic [PTR_W-1:0]  ptr;

    logic              slot_free_c;
    logic [PORT_NUM-1:0] req_c;
    logic [PORT_NUM-1:0] grant_c;
    commit_entry_t     sel_c;
    logic [PTR_W-1:0]  grant_idx_c;
    logic [PTR_W-1:0]  ptr_next_c;

    // Slot can take a new entry when empty or being drained this cycle
    assign slot_free_c = !slot_valid || bus.rob_ready;
    assign req_c       = (slot_free_c && !bus.flush && !rst) ? bus.can_commit : '0;

    rob_commit_arb_rr_arbiter #(
        .N     (PORT_NUM),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_c),
        .ptr   (ptr),
        .grant (grant_c)
    );

    // One-hot AND-OR mux of the granted payload and its index
    always_comb begin
        sel_c       = '0;
        grant_idx_c = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            sel_c.addr     |= bus.commit_addr[i]     & {ROB_ADDR_W{grant_c[i]}};
            sel_c.exc_type |= bus.commit_exc_type[i] & {EXC_TYPE_W{grant_c[i]}};
            sel_c.data     |= bus.commit_data[i]     & {DATA_W{grant_c[i]}};
            grant_idx_c    |= PTR_W'(i)              & {PTR_W{grant_c[i]}};
        end
        ptr_next_c = (grant_idx_c == PTR_W'(PORT_NUM - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    end

    // Slot and pointer update; flush and reset override any drain/grant
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot       <= '0;
            ptr        <= '0;
        end else if (bus.flush) begin
            slot_valid <= 1'b0;
        end else if (|grant_c) begin
            slot_valid <= 1'b1;
            slot       <= sel_c;
            ptr        <= ptr_next_c;
        end else if (slot_valid && bus.rob_ready) begin
            slot_valid <= 1'b0;
        end
    end

    assign bus.commit_en    = grant_c;
    assign bus.rob_write_en = slot_valid;
    assign bus.rob_addr     = slot.addr;
    assign bus.rob_exc_type = slot.exc_type;
    assign bus.rob_data     = slot.data;

endmodule
